// File: rtl/fpga_ctrl_pkg.sv
// fpga_ctrl_pkg: shared state type for the LED event stretcher
package fpga_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_GAP} stretch_state_t;
endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down counter that parks at zero
module load_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign zero = r_cnt == '0;
endmodule

// File: rtl/led_event_stretcher.sv
// led_event_stretcher: stretches event strobes into visible LED pulses with forced gaps and a pending queue
module led_event_stretcher
  import fpga_ctrl_pkg::*;
#(
  parameter int TW      = 16,
  parameter int ON_CNT  = 50000,
  parameter int GAP_CNT = 25000,
  parameter int PEND_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_in,
  input  logic              clear_ovf,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);
  localparam logic [TW-1:0]     ON_LD    = TW'(ON_CNT - 1);
  localparam logic [TW-1:0]     GAP_LD   = TW'(GAP_CNT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  stretch_state_t    r_state, w_next;
  logic              r_led, r_busy, r_ovf;
  logic [PEND_W-1:0] r_pend, w_pend;
  logic              w_zero, w_start, w_on_end, w_gap_end, w_consume, w_load, w_inc, w_drop, w_ovf;
  logic [TW-1:0]     w_load_val;
  load_down_counter #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );
  always_comb begin
    w_start    = r_state == ST_IDLE && evt_in;
    w_on_end   = r_state == ST_ON && w_zero;
    w_gap_end  = r_state == ST_GAP && w_zero;
    w_consume  = w_gap_end && (r_pend != '0 || evt_in);
    w_load     = w_start || w_on_end || w_consume;
    w_load_val = w_on_end ? GAP_LD : ON_LD;
    w_next     = (w_start || w_consume) ? ST_ON :
                 w_on_end               ? ST_GAP :
                 w_gap_end              ? ST_IDLE : r_state;
    // an event coincident with a consume either replaces the dequeued one or is shown directly
    w_inc      = evt_in && r_state != ST_IDLE && !w_consume;
    w_drop     = w_inc && r_pend == PEND_MAX;
    w_pend     = w_consume ? (evt_in ? r_pend : r_pend - 1'b1) :
                 (w_inc && !w_drop) ? r_pend + 1'b1 : r_pend;
    w_ovf      = w_drop || (r_ovf && !clear_ovf);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= ST_IDLE;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_led   <= w_next == ST_ON;
      r_busy  <= w_next != ST_IDLE;
      r_pend  <= w_pend;
      r_ovf   <= w_ovf;
    end
  assign led_out  = r_led;
  assign busy     = r_busy;
  assign pend_cnt = r_pend;
  assign overflow = r_ovf;
  ap_cnt_legal: assert property (@(posedge clk) disable iff (!rst)
    ON_CNT >= 1 && GAP_CNT >= 1 && ON_CNT < 2**TW && GAP_CNT < 2**TW);
endmodule

// File: tb/tb_led_event_stretcher.sv
// tb_led_event_stretcher: scoreboard bench for LED timing, pending queue, overflow and async reset
module tb_led_event_stretcher;
  localparam int ON  = 4;
  localparam int GAP = 2;
  localparam int PER = ON + GAP;
  logic       clk = 1'b0, rst = 1'b1, evt_in = 1'b0, clear_ovf = 1'b0;
  logic       led_out, busy, overflow;
  logic [1:0] pend_cnt;
  int         total = 0, bad = 0;
  logic [1:0] exp_q[$];
  logic [1:0] pend_seen[64];
  logic       ovf_seen[64];
  led_event_stretcher #(.TW(16), .ON_CNT(ON), .GAP_CNT(GAP), .PEND_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .evt_in    (evt_in),
    .clear_ovf (clear_ovf),
    .led_out   (led_out),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .overflow  (overflow)
  );
  always #5 clk = ~clk;
  // pulses start at cycle 1 and follow each other every ON+GAP cycles
  task automatic run_seq(input string name, input logic [63:0] evt_m, input logic [63:0] clr_m,
                         input int n_cyc, input int n_pulses);
    logic [1:0] e;
    for (int c = 0; c < n_cyc; c++)
      exp_q.push_back({c >= 1 && c < 1 + PER * n_pulses && (c - 1) % PER < ON,
                       c >= 1 && c < 1 + PER * n_pulses});
    for (int c = 0; c < n_cyc; c++) begin
      e = exp_q.pop_front();
      total++;
      if ({led_out, busy} !== e) begin
        bad++;
        $display("FAIL %s cycle %0d led,busy got=%b%b want=%b", name, c, led_out, busy, e);
      end
      pend_seen[c] = pend_cnt;
      ovf_seen[c]  = overflow;
      evt_in       = evt_m[c];
      clear_ovf    = clr_m[c];
      @(negedge clk);
    end
    evt_in    = 1'b0;
    clear_ovf = 1'b0;
  endtask
  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({led_out, busy, pend_cnt, overflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset outputs got=%b want=00000", {led_out, busy, pend_cnt, overflow});
    end
    #19 rst = 1'b1;
  endtask
  task automatic test_single();
    @(negedge clk);
    run_seq("single", 64'h1, 64'h0, 10, 1);
    total++;
    if (pend_seen[9] !== 2'd0) begin
      bad++;
      $display("FAIL single_pend got=%0d want=0", pend_seen[9]);
    end
  endtask
  task automatic test_back_to_back();
    logic [1:0] m;
    @(negedge clk);
    run_seq("b2b", 64'hD, 64'h0, 22, 3);
    m = 2'd0;
    for (int c = 0; c < 22; c++) if (pend_seen[c] > m) m = pend_seen[c];
    total++;
    if (m !== 2'd2) begin bad++; $display("FAIL b2b_peak got=%0d want=2", m); end
    total++;
    if (pend_seen[7] !== 2'd1) begin bad++; $display("FAIL b2b_pend7 got=%0d want=1", pend_seen[7]); end
    total++;
    if (pend_seen[13] !== 2'd0) begin bad++; $display("FAIL b2b_pend13 got=%0d want=0", pend_seen[13]); end
  endtask
  task automatic test_overflow();
    @(negedge clk);
    run_seq("ovf", 64'h1F, 64'h14 | (64'h1 << 26), 28, 4);
    total++;
    if (pend_seen[4] !== 2'd3 || ovf_seen[4] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_c4 pend,ovf got=%0d,%b want=3,0", pend_seen[4], ovf_seen[4]);
    end
    total++;
    if (pend_seen[5] !== 2'd3 || ovf_seen[5] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set_over_clear pend,ovf got=%0d,%b want=3,1", pend_seen[5], ovf_seen[5]);
    end
    total++;
    if (pend_seen[7] !== 2'd2) begin bad++; $display("FAIL ovf_pend7 got=%0d want=2", pend_seen[7]); end
    total++;
    if (ovf_seen[26] !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf_seen[26]); end
    total++;
    if (ovf_seen[27] !== 1'b0 || pend_seen[27] !== 2'd0) begin
      bad++;
      $display("FAIL ovf_clear ovf,pend got=%b,%0d want=0,0", ovf_seen[27], pend_seen[27]);
    end
  endtask
  task automatic test_gap_last_cycle();
    @(negedge clk);
    run_seq("gap_last", 64'h45, 64'h0, 22, 3);
    total++;
    if (pend_seen[6] !== 2'd1) begin bad++; $display("FAIL gap_last_pend6 got=%0d want=1", pend_seen[6]); end
    total++;
    if (pend_seen[7] !== 2'd1) begin bad++; $display("FAIL gap_last_pend7 got=%0d want=1", pend_seen[7]); end
    total++;
    if (pend_seen[13] !== 2'd0) begin bad++; $display("FAIL gap_last_pend13 got=%0d want=0", pend_seen[13]); end
  endtask
  task automatic test_gap_evt();
    @(negedge clk);
    run_seq("gap_evt", 64'h21, 64'h0, 16, 2);
    total++;
    if (pend_seen[6] !== 2'd1) begin bad++; $display("FAIL gap_evt_pend6 got=%0d want=1", pend_seen[6]); end
    total++;
    if (pend_seen[7] !== 2'd0) begin bad++; $display("FAIL gap_evt_pend7 got=%0d want=0", pend_seen[7]); end
  endtask
  task automatic test_async_reset();
    @(negedge clk);
    run_seq("pre_rst", 64'h7, 64'h0, 4, 1);
    total++;
    if (led_out !== 1'b1 || pend_cnt !== 2'd2) begin
      bad++;
      $display("FAIL pre_rst led,pend got=%b,%0d want=1,2", led_out, pend_cnt);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({led_out, busy, pend_cnt, overflow} !== 5'b0) begin
      bad++;
      $display("FAIL async_rst outputs got=%b want=00000", {led_out, busy, pend_cnt, overflow});
    end
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    run_seq("post_rst", 64'h0, 64'h0, 10, 0);
    total++;
    if (pend_seen[9] !== 2'd0) begin bad++; $display("FAIL post_rst_pend got=%0d want=0", pend_seen[9]); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_gap_last_cycle();
    test_gap_evt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
